spec_accum_stage: RTL and testbench
===================================

SPEC_ACCUM_STAGE -- requirements
Module: spec_accum_stage

Interface
REQ-001 Parameter WIDTH, default 5: operand, accumulator and result width in bits; legal range 2..32.
REQ-002 Parameter ACC_MODE, default 1: 1 = accumulate, acc + Data1 + Data2 - Data3; 0 = pass-through, Data1 + Data2 - Data3.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 In_Valid  input  1  operands are valid this cycle.
REQ-006 Clear  input  1  synchronous accumulator clear.
REQ-007 Data1, Data2  input  WIDTH each  unsigned addends.
REQ-008 Data3  input  WIDTH  unsigned subtrahend.
REQ-009 Out_Valid  output  1  registered result is valid.
REQ-010 Out_Data  output  WIDTH  registered result; equals the accumulator state.
REQ-011 Carry  output  2  registered signed carry: 01 = overflow, 11 = underflow, 00 = none.

Function
REQ-012 Each In_Valid cycle SHALL compute sum = base + Data1 + Data2 - Data3 at WIDTH+2 bits signed; base = Out_Data if ACC_MODE=1, else 0.
REQ-013 Sum >= 2^WIDTH SHALL set Carry = 01; sum < 0 SHALL set Carry = 11; otherwise Carry = 00.
REQ-014 Without saturation, Out_Data SHALL load sum[WIDTH-1:0], i.e. modulo 2^WIDTH wrap.
REQ-015 Latency SHALL be exactly 1 cycle: Out_Valid, Out_Data and Carry update on the edge that samples In_Valid=1.
REQ-016 With In_Valid=0, Out_Valid SHALL be 0 next cycle, Carry SHALL be 00, and Out_Data SHALL hold.
REQ-017 Clear=1 SHALL force Out_Data to 0, Carry to 00 and Out_Valid to 0 next cycle; Clear takes priority over In_Valid in the same cycle.
REQ-018 After Clear, the next valid input SHALL accumulate from 0.
REQ-019 Back-to-back In_Valid SHALL be accepted every cycle; there is no backpressure.
REQ-020 Arithmetic SHALL be exact for all operand values, including Data1 = Data2 = 2^WIDTH-1 with Data3 = 0, and Data1 = Data2 = 0 with Data3 = 2^WIDTH-1.

Reset
REQ-021 While rst_n=0, Out_Data = 0, Carry = 00 and Out_Valid = 0, independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard accumulator state; the first valid input after release accumulates from 0.
REQ-023 rst_n SHALL assert asynchronously; release is assumed synchronised externally.

Configuration
REQ-024 Macro SPEC_ACCUM_SAT_EN, when defined, SHALL clamp Out_Data to 2^WIDTH-1 on overflow and to 0 on underflow; Carry is still reported per REQ-013.
REQ-025 Without SPEC_ACCUM_SAT_EN, wrap behaviour per REQ-014 SHALL apply and no clamp logic is generated.

Structure
REQ-026 Carry encodings (CARRY_NONE = 00, CARRY_OVF = 01, CARRY_UNF = 11) SHALL be defined in shared package dsm_pkg.
REQ-027 The combinational three-operand adder SHALL be sub-module spec_adder_w, parametrised by WIDTH and producing the WIDTH+2-bit signed sum.
REQ-028 Registers, clear/valid control and the saturation mux SHALL reside in spec_accum_stage.

Verification (WIDTH=5, ACC_MODE=1 unless stated)
REQ-029 Accumulate: reset, then cycle 1 applies D1=3, D2=4, D3=2; cycle 2 applies D1=10, D2=10, D3=0 -> Out_Data=5 with Carry=00, then Out_Data=25 with Carry=00; Out_Valid high both cycles.
REQ-030 Overflow: acc=25, then D1=5, D2=4, D3=0 (sum 34) -> wrap build gives Out_Data=2, Carry=01; SAT build gives Out_Data=31, Carry=01.
REQ-031 Underflow: acc=1, then D1=0, D2=0, D3=3 -> wrap build gives Out_Data=30, Carry=11; SAT build gives Out_Data=0, Carry=11.
REQ-032 Clear priority: Clear=1 with In_Valid=1 and D1=7 -> Out_Data=0, Out_Valid=0; next cycle D1=7 -> Out_Data=7.
REQ-033 Async reset: drop rst_n between clock edges while acc=20 -> Out_Data=0 and Out_Valid=0 immediately; after release, D1=1 gives Out_Data=1.
REQ-034 Pass-through (ACC_MODE=0): D1=31, D2=31, D3=0 -> Out_Data=30, Carry=01 (wrap build); then In_Valid=0 -> Out_Valid=0, Out_Data holds 30.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared definitions for the accumulator stage: carry encodings and the
// carry classification helper.
package dsm_pkg;

    typedef enum logic [1:0] {
        CARRY_NONE = 2'b00,
        CARRY_OVF  = 2'b01,
        CARRY_UNF  = 2'b11
    } carry_e;

    // A sum that fits in the result width has both guard bits clear.
    function automatic carry_e classify_carry(input logic neg, input logic [1:0] guard);
        if (neg) begin
            return CARRY_UNF;
        end else if (guard != 2'b00) begin
            return CARRY_OVF;
        end
        return CARRY_NONE;
    endfunction

endpackage

// File: rtl/spec_accum_stage_if.sv
// Operand/result bundle of spec_accum_stage; master drives operands, slave
// returns the registered result.
interface spec_accum_stage_if #(
    parameter int unsigned WIDTH = 5
);
    logic             In_Valid;
    logic             Clear;
    logic [WIDTH-1:0] Data1;
    logic [WIDTH-1:0] Data2;
    logic [WIDTH-1:0] Data3;
    logic             Out_Valid;
    logic [WIDTH-1:0] Out_Data;
    logic [1:0]       Carry;

    modport master (
        output In_Valid, Clear, Data1, Data2, Data3,
        input  Out_Valid, Out_Data, Carry
    );

    modport slave (
        input  In_Valid, Clear, Data1, Data2, Data3,
        output Out_Valid, Out_Data, Carry
    );
endinterface

// File: rtl/spec_adder_w.sv
// Combinational three-operand adder: base + a + b - c as a WIDTH+2-bit
// signed sum plus the true sign of the exact result.
module spec_adder_w #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0]        base,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [WIDTH-1:0]        c,
    output logic signed [WIDTH+1:0] sum,
    output logic                    neg
);

    // With a non-zero base the positive range reaches 3*(2^WIDTH-1), which
    // does not fit WIDTH+2 signed bits; one extra bit keeps the sign exact.
    logic signed [WIDTH+2:0] full;

    always_comb begin
        full = $signed({3'b000, base}) + $signed({3'b000, a})
             + $signed({3'b000, b}) - $signed({3'b000, c});
    end

    assign sum = full[WIDTH+1:0];
    assign neg = full[WIDTH+2];

endmodule

// File: rtl/spec_accum_stage.sv
// Single-cycle accumulate/pass-through stage with wrap or clamp on range
// excursions. Optional clamping is enabled by defining SPEC_ACCUM_SAT_EN.
module spec_accum_stage
    import dsm_pkg::*;
#(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned ACC_MODE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    spec_accum_stage_if.slave   bus
);

    logic [WIDTH-1:0]        base;
    logic signed [WIDTH+1:0] sum;
    logic                    neg;
    carry_e                  carry_d, carry_q;
    logic [WIDTH-1:0]        data_d, data_q;
    logic                    valid_q;

    assign base = (ACC_MODE != 0) ? data_q : '0;

    spec_adder_w #(
        .WIDTH (WIDTH)
    ) u_adder (
        .base (base),
        .a    (bus.Data1),
        .b    (bus.Data2),
        .c    (bus.Data3),
        .sum  (sum),
        .neg  (neg)
    );

    always_comb begin
        carry_d = classify_carry(neg, sum[WIDTH+1:WIDTH]);
`ifdef SPEC_ACCUM_SAT_EN
        unique case (carry_d)
            CARRY_OVF: data_d = '1;
            CARRY_UNF: data_d = '0;
            default:   data_d = sum[WIDTH-1:0];
        endcase
`else
        data_d = sum[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            carry_q <= CARRY_NONE;
            valid_q <= 1'b0;
        end else if (bus.Clear) begin
            data_q  <= '0;
            carry_q <= CARRY_NONE;
            valid_q <= 1'b0;
        end else if (bus.In_Valid) begin
            data_q  <= data_d;
            carry_q <= carry_d;
            valid_q <= 1'b1;
        end else begin
            carry_q <= CARRY_NONE;
            valid_q <= 1'b0;
        end
    end

    assign bus.Out_Valid = valid_q;
    assign bus.Out_Data  = data_q;
    assign bus.Carry     = carry_q;

endmodule

// File: tb/tb_spec_accum_stage.sv
// Randomised bench for spec_accum_stage: an accumulating and a pass-through
// instance share stimulus and are compared against an arithmetic model.
module tb_spec_accum_stage;
    import dsm_pkg::*;

    localparam int unsigned W    = 5;
    localparam int          MAXV = (1 << W) - 1;
`ifdef SPEC_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spec_accum_stage_if #(.WIDTH(W)) bus_a ();
    spec_accum_stage_if #(.WIDTH(W)) bus_p ();

    spec_accum_stage #(.WIDTH(W), .ACC_MODE(1)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    spec_accum_stage #(.WIDTH(W), .ACC_MODE(0)) u_pass (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p)
    );

    int n_vec = 0;
    int n_err = 0;
    // Index 0: accumulating instance, index 1: pass-through instance.
    int exp_v[2];
    int exp_d[2];
    int exp_c[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_v[i] = 0;
            exp_d[i] = 0;
            exp_c[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit v, input bit clr,
                              input int d1, input int d2, input int d3);
        int s;
        if (clr) begin
            exp_v[i] = 0;
            exp_d[i] = 0;
            exp_c[i] = 0;
        end else if (v) begin
            s = ((i == 0) ? exp_d[i] : 0) + d1 + d2 - d3;
            exp_c[i] = (s > MAXV) ? 1 : ((s < 0) ? 3 : 0);
            if (SAT && s > MAXV)   exp_d[i] = MAXV;
            else if (SAT && s < 0) exp_d[i] = 0;
            else                   exp_d[i] = s & MAXV;
            exp_v[i] = 1;
        end else begin
            exp_v[i] = 0;
            exp_c[i] = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".acc.valid"}, 32'(bus_a.Out_Valid), exp_v[0]);
        check({tag, ".acc.data"},  32'(bus_a.Out_Data),  exp_d[0]);
        check({tag, ".acc.carry"}, 32'(bus_a.Carry),     exp_c[0]);
        check({tag, ".pass.valid"}, 32'(bus_p.Out_Valid), exp_v[1]);
        check({tag, ".pass.data"},  32'(bus_p.Out_Data),  exp_d[1]);
        check({tag, ".pass.carry"}, 32'(bus_p.Carry),     exp_c[1]);
    endtask

    task automatic cycle(input string tag, input bit v, input bit clr,
                         input int d1, input int d2, input int d3);
        bus_a.In_Valid = v;   bus_p.In_Valid = v;
        bus_a.Clear    = clr; bus_p.Clear    = clr;
        bus_a.Data1 = W'(d1); bus_p.Data1 = W'(d1);
        bus_a.Data2 = W'(d2); bus_p.Data2 = W'(d2);
        bus_a.Data3 = W'(d3); bus_p.Data3 = W'(d3);
        @(posedge clk);
        #1;
        model_step(0, v, clr, d1, d2, d3);
        model_step(1, v, clr, d1, d2, d3);
        compare_all(tag);
    endtask

    function automatic int pick();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? MAXV : 0;
        return int'($urandom_range(0, MAXV));
    endfunction

    initial begin
        model_reset();
        bus_a.In_Valid = 0; bus_a.Clear = 0; bus_a.Data1 = 0; bus_a.Data2 = 0; bus_a.Data3 = 0;
        bus_p.In_Valid = 1; bus_p.Clear = 0; bus_p.Data1 = 3; bus_p.Data2 = 0; bus_p.Data3 = 0;

        // Outputs stay cleared under reset even with clock edges and valid input.
        #22;
        compare_all("reset");
        bus_p.In_Valid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        cycle("acc1", 1, 0, 3, 4, 2);
        check("acc1.lit", 32'(bus_a.Out_Data), 5);
        cycle("acc2", 1, 0, 10, 10, 0);
        check("acc2.lit", 32'(bus_a.Out_Data), 25);
        cycle("ovf", 1, 0, 5, 4, 0);
        check("ovf.lit", 32'(bus_a.Out_Data), SAT ? 31 : 2);
        check("ovf.carry.lit", 32'(bus_a.Carry), 32'(CARRY_OVF));

        cycle("clr", 0, 1, 0, 0, 0);
        cycle("one", 1, 0, 1, 0, 0);
        cycle("unf", 1, 0, 0, 0, 3);
        check("unf.lit", 32'(bus_a.Out_Data), SAT ? 0 : 30);
        check("unf.carry.lit", 32'(bus_a.Carry), 32'(CARRY_UNF));

        cycle("clrpri", 1, 1, 7, 0, 0);
        check("clrpri.lit", 32'(bus_a.Out_Valid), 0);
        cycle("afterclr", 1, 0, 7, 0, 0);
        check("afterclr.lit", 32'(bus_a.Out_Data), 7);

        // Exact arithmetic at the operand extremes, including acc + max + max.
        cycle("clr2", 0, 1, 0, 0, 0);
        cycle("maxmax", 1, 0, MAXV, MAXV, 0);
        cycle("clr3", 0, 1, 0, 0, 0);
        cycle("minsub", 1, 0, 0, 0, MAXV);
        cycle("clr4", 0, 1, 0, 0, 0);
        cycle("fill", 1, 0, MAXV, 0, 0);
        cycle("top", 1, 0, MAXV, MAXV, 0);
        check("top.carry.lit", 32'(bus_a.Carry), 32'(CARRY_OVF));

        cycle("clr5", 0, 1, 0, 0, 0);
        cycle("twenty", 1, 0, 20, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async");
        check("async.lit", 32'(bus_a.Out_Data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("postrst", 1, 0, 1, 0, 0);
        check("postrst.lit", 32'(bus_a.Out_Data), 1);

        cycle("pass", 1, 0, 31, 31, 0);
        check("pass.lit", 32'(bus_p.Out_Data), SAT ? 31 : 30);
        check("pass.carry.lit", 32'(bus_p.Carry), 32'(CARRY_OVF));
        cycle("passhold", 0, 0, 5, 5, 5);
        check("passhold.lit", 32'(bus_p.Out_Data), SAT ? 31 : 30);

        for (int k = 0; k < 300; k++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                  pick(), pick(), pick());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
